wb_stage: RTL and testbench

WB_STAGE -- requirements
Module: wb_stage

---
 rtl/wb_pkg.sv | 33 +++
 rtl/wb_vec_serializer.sv | 69 ++++++
 rtl/wb_stage.sv | 127 ++++++++++++
 tb/tb_wb_stage.sv | 303 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/wb_pkg.sv
// wb_pkg: shared types and sizing helpers for the writeback stage.
// Holds the serializer FSM state type, the default number of vector write
// beats and the derived beat-index / slice widths used by wb_stage and
// wb_vec_serializer.
package wb_pkg;

  // Serializer state: IDLE when no vector beats remain, VWR while a
  // multi-beat vector write is being streamed into the vector regfile.
  typedef enum logic {
    IDLE = 1'b0,
    VWR  = 1'b1
  } wbState_t;

  // Default geometry of the vector register write port.
  localparam int VWR_BEATS_DEF = 2;
  localparam int VECT_SIZE_DEF = 8;
  localparam int ELEM_SIZE_DEF = 8;
  localparam int VEC_W_DEF     = VECT_SIZE_DEF * ELEM_SIZE_DEF;

  // Width of the beat index; a single-beat port still needs one bit.
  function automatic int beatWidth(input int beats);
    return (beats > 1) ? $clog2(beats) : 1;
  endfunction

  // Width of the vector slice written per beat.
  function automatic int sliceWidth(input int vecW, input int beats);
    return vecW / beats;
  endfunction

  localparam int BEAT_W_DEF  = beatWidth(VWR_BEATS_DEF);
  localparam int SLICE_W_DEF = sliceWidth(VEC_W_DEF, VWR_BEATS_DEF);

endpackage

// File: rtl/wb_vec_serializer.sv
// wb_vec_serializer: streams one captured vector result into the vector
// register file as VWR_BEATS consecutive slices, LSB slice first.
// Owns the IDLE/VWR state, the beat counter, the slice mux and the
// registered vecWe/vecBeat/vecData outputs. slotFree_o tells the stage
// whether a new entry may be accepted this cycle (idle, or showing the
// final beat so the next entry's beat 0 follows without a bubble).
module wb_vec_serializer
  import wb_pkg::*;
#(
  parameter int VEC_W     = VEC_W_DEF,
  parameter int VWR_BEATS = VWR_BEATS_DEF,
  localparam int SLICE_W  = sliceWidth(VEC_W, VWR_BEATS),
  localparam int BEAT_W   = beatWidth(VWR_BEATS)
) (
  input  logic               clk_i,
  input  logic               rst_i,
  input  logic               start_i,
  input  logic [VEC_W-1:0]   startVec_i,
  input  logic [VEC_W-1:0]   heldVec_i,
  output logic               vecWe_o,
  output logic [BEAT_W-1:0]  vecBeat_o,
  output logic [SLICE_W-1:0] vecData_o,
  output logic               slotFree_o
);

  localparam logic [BEAT_W-1:0] LAST_BEAT = BEAT_W'(VWR_BEATS - 1);

  wbState_t           state;
  logic [BEAT_W-1:0]  beatCnt;
  logic [BEAT_W-1:0]  nextBeat;
  logic [SLICE_W-1:0] nextSlice;
  logic               lastBeat;

  // Select the slice of the held vector belonging to the following beat.
  always_comb begin
    nextBeat  = beatCnt + 1'b1;
    nextSlice = heldVec_i[nextBeat*SLICE_W +: SLICE_W];
  end

  assign lastBeat   = (beatCnt == LAST_BEAT);
  assign slotFree_o = (state == IDLE) || lastBeat;
  assign vecBeat_o  = beatCnt;

  // Beat sequencing: a start presents beat 0 straight from the incoming
  // vector, later beats come from the held copy, and the counter returns
  // to 0 once the last beat has been presented.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state     <= IDLE;
      beatCnt   <= '0;
      vecWe_o   <= 1'b0;
      vecData_o <= '0;
    end else if (start_i) begin
      state     <= (VWR_BEATS > 1) ? VWR : IDLE;
      beatCnt   <= '0;
      vecWe_o   <= 1'b1;
      vecData_o <= startVec_i[SLICE_W-1:0];
    end else if ((state == VWR) && !lastBeat) begin
      beatCnt   <= nextBeat;
      vecWe_o   <= 1'b1;
      vecData_o <= nextSlice;
    end else begin
      state     <= IDLE;
      beatCnt   <= '0;
      vecWe_o   <= 1'b0;
    end
  end

endmodule

// File: rtl/wb_stage.sv
// wb_stage: pipeline writeback stage.
// Accepts one entry per valid/ready handshake, selects the integer and
// vector results (memory or ALU), writes the integer regfile in the cycle
// after acceptance and streams the vector result over VWR_BEATS cycles
// through wb_vec_serializer.
// Optional feature: define WB_FWD_EN to drive the forwarding ports back
// to execute; without it those ports are tied to zero.
module wb_stage
  import wb_pkg::*;
#(
  parameter int REGI_BITS = 4,
  parameter int VECT_BITS = 2,
  parameter int REGI_SIZE = 16,
  parameter int VECT_SIZE = VECT_SIZE_DEF,
  parameter int ELEM_SIZE = ELEM_SIZE_DEF,
  parameter int VWR_BEATS = VWR_BEATS_DEF,
  localparam int VEC_W    = ELEM_SIZE * VECT_SIZE,
  localparam int SLICE_W  = sliceWidth(VEC_W, VWR_BEATS),
  localparam int BEAT_W   = beatWidth(VWR_BEATS)
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic                 valid_i,
  output logic                 ready_o,
  input  logic [REGI_SIZE-1:0] ialu_res_i,
  input  logic [VEC_W-1:0]     valu_res_i,
  input  logic [VEC_W-1:0]     memo_res_i,
  input  logic                 flagMemRead_i,
  input  logic                 writeResultInt_i,
  input  logic                 writeResultV_i,
  input  logic [REGI_BITS-1:0] intRegDest_i,
  input  logic [VECT_BITS-1:0] vecRegDest_i,
  output logic                 intWe_o,
  output logic [REGI_BITS-1:0] intAddr_o,
  output logic [REGI_SIZE-1:0] intData_o,
  output logic                 vecWe_o,
  output logic [VECT_BITS-1:0] vecAddr_o,
  output logic [BEAT_W-1:0]    vecBeat_o,
  output logic [SLICE_W-1:0]   vecData_o,
  output logic                 fwdIntValid_o,
  output logic [REGI_BITS-1:0] fwdIntReg_o,
  output logic [REGI_SIZE-1:0] fwdIntData_o,
  output logic                 fwdVecValid_o,
  output logic [VECT_BITS-1:0] fwdVecReg_o,
  output logic [VEC_W-1:0]     fwdVecData_o
);

  logic                 slotFree;
  logic                 accept;
  logic                 intWrite;
  logic                 vecStart;
  logic [REGI_SIZE-1:0] intSel;
  logic [VEC_W-1:0]     vecSel;
  logic [VEC_W-1:0]     capVec;

  // Result source selection: memory read data overrides the ALUs.
  always_comb begin
    intSel = flagMemRead_i ? memo_res_i[REGI_SIZE-1:0] : ialu_res_i;
    vecSel = flagMemRead_i ? memo_res_i : valu_res_i;
  end

  // Register 0 is hardwired, so a write aimed at it is silently dropped.
  assign ready_o  = !rst_i && slotFree;
  assign accept   = valid_i && ready_o;
  assign intWrite = accept && writeResultInt_i && (intRegDest_i != '0);
  assign vecStart = accept && writeResultV_i;

  // Integer write port: one-cycle pulse carrying the captured address/data.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      intWe_o   <= 1'b0;
      intAddr_o <= '0;
      intData_o <= '0;
    end else if (intWrite) begin
      intWe_o   <= 1'b1;
      intAddr_o <= intRegDest_i;
      intData_o <= intSel;
    end else begin
      intWe_o   <= 1'b0;
    end
  end

  // Hold the accepted vector and its destination for the remaining beats.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      capVec    <= '0;
      vecAddr_o <= '0;
    end else if (vecStart) begin
      capVec    <= vecSel;
      vecAddr_o <= vecRegDest_i;
    end
  end

  wb_vec_serializer #(
    .VEC_W     (VEC_W),
    .VWR_BEATS (VWR_BEATS)
  ) u_serializer (
    .clk_i      (clk_i),
    .rst_i      (rst_i),
    .start_i    (vecStart),
    .startVec_i (vecSel),
    .heldVec_i  (capVec),
    .vecWe_o    (vecWe_o),
    .vecBeat_o  (vecBeat_o),
    .vecData_o  (vecData_o),
    .slotFree_o (slotFree)
  );

`ifdef WB_FWD_EN
  // Forwarding taps the registered write ports; the vector forward shows
  // the whole captured vector for every beat of the entry.
  assign fwdIntValid_o = intWe_o;
  assign fwdIntReg_o   = intAddr_o;
  assign fwdIntData_o  = intData_o;
  assign fwdVecValid_o = vecWe_o;
  assign fwdVecReg_o   = vecAddr_o;
  assign fwdVecData_o  = capVec;
`else
  assign fwdIntValid_o = 1'b0;
  assign fwdIntReg_o   = '0;
  assign fwdIntData_o  = '0;
  assign fwdVecValid_o = 1'b0;
  assign fwdVecReg_o   = '0;
  assign fwdVecData_o  = '0;
`endif

endmodule

// File: tb/tb_wb_stage.sv
// tb_wb_stage: directed and randomized bench for wb_stage.
// A queue of pending vector beats and a pending integer write form the
// reference model; every cycle the DUT outputs are compared with it.
// Forwarding expectations follow the WB_FWD_EN macro.
module tb_wb_stage;

  localparam int REGI_BITS = 4;
  localparam int VECT_BITS = 2;
  localparam int REGI_SIZE = 16;
  localparam int VECT_SIZE = 8;
  localparam int ELEM_SIZE = 8;
  localparam int VWR_BEATS = 2;
  localparam int VW        = ELEM_SIZE * VECT_SIZE;
  localparam int SW        = VW / VWR_BEATS;
  localparam int BW        = 1;

  logic                 clk = 1'b0;
  logic                 rst;
  logic                 valid;
  logic                 ready;
  logic [REGI_SIZE-1:0] ialu;
  logic [VW-1:0]        valu;
  logic [VW-1:0]        memo;
  logic                 fmr;
  logic                 wi;
  logic                 wv;
  logic [REGI_BITS-1:0] idest;
  logic [VECT_BITS-1:0] vdest;
  logic                 intWe;
  logic [REGI_BITS-1:0] intAddr;
  logic [REGI_SIZE-1:0] intData;
  logic                 vecWe;
  logic [VECT_BITS-1:0] vecAddr;
  logic [BW-1:0]        vecBeat;
  logic [SW-1:0]        vecData;
  logic                 fwdIntValid;
  logic [REGI_BITS-1:0] fwdIntReg;
  logic [REGI_SIZE-1:0] fwdIntData;
  logic                 fwdVecValid;
  logic [VECT_BITS-1:0] fwdVecReg;
  logic [VW-1:0]        fwdVecData;

  always #5 clk = ~clk;

  wb_stage #(
    .REGI_BITS (REGI_BITS),
    .VECT_BITS (VECT_BITS),
    .REGI_SIZE (REGI_SIZE),
    .VECT_SIZE (VECT_SIZE),
    .ELEM_SIZE (ELEM_SIZE),
    .VWR_BEATS (VWR_BEATS)
  ) dut (
    .clk_i            (clk),
    .rst_i            (rst),
    .valid_i          (valid),
    .ready_o          (ready),
    .ialu_res_i       (ialu),
    .valu_res_i       (valu),
    .memo_res_i       (memo),
    .flagMemRead_i    (fmr),
    .writeResultInt_i (wi),
    .writeResultV_i   (wv),
    .intRegDest_i     (idest),
    .vecRegDest_i     (vdest),
    .intWe_o          (intWe),
    .intAddr_o        (intAddr),
    .intData_o        (intData),
    .vecWe_o          (vecWe),
    .vecAddr_o        (vecAddr),
    .vecBeat_o        (vecBeat),
    .vecData_o        (vecData),
    .fwdIntValid_o    (fwdIntValid),
    .fwdIntReg_o      (fwdIntReg),
    .fwdIntData_o     (fwdIntData),
    .fwdVecValid_o    (fwdVecValid),
    .fwdVecReg_o      (fwdVecReg),
    .fwdVecData_o     (fwdVecData)
  );

  // One scheduled vector write beat; the head of the queue is the beat
  // that should be visible in the current cycle.
  typedef struct {
    logic [VECT_BITS-1:0] addr;
    int                   beat;
    logic [SW-1:0]        data;
    logic [VW-1:0]        full;
  } beat_t;

  beat_t                beatQ[$];
  logic                 expIntWe   = 1'b0;
  logic [REGI_BITS-1:0] expIntAddr = '0;
  logic [REGI_SIZE-1:0] expIntData = '0;
  int                   checks     = 0;
  int                   failures   = 0;

  task automatic checkEq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("[TB] FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic applyStimulus(input logic v, input logic f, input logic i, input logic w,
                               input logic [REGI_SIZE-1:0] ia, input logic [VW-1:0] va,
                               input logic [VW-1:0] mo, input logic [REGI_BITS-1:0] id,
                               input logic [VECT_BITS-1:0] vd);
    valid = v; fmr = f; wi = i; wv = w;
    ialu = ia; valu = va; memo = mo; idest = id; vdest = vd;
  endtask

  task automatic idleInputs();
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, '0, '0, '0, '0, '0);
  endtask

  // Reference model update for one rising edge, using the applied inputs.
  task automatic modelEdge();
    logic          accept;
    logic [VW-1:0] vsel;
    beat_t         b;
    if (rst) begin
      beatQ.delete();
      expIntWe = 1'b0;
      return;
    end
    accept = valid && (beatQ.size() <= 1);
    if (beatQ.size() > 0) void'(beatQ.pop_front());
    expIntWe = 1'b0;
    if (accept) begin
      vsel = fmr ? memo : valu;
      if (wi && idest != 0) begin
        expIntWe   = 1'b1;
        expIntAddr = idest;
        expIntData = fmr ? memo[REGI_SIZE-1:0] : ialu;
      end
      if (wv) begin
        for (int k = 0; k < VWR_BEATS; k++) begin
          b.addr = vdest;
          b.beat = k;
          b.data = SW'(vsel >> (k * SW));
          b.full = vsel;
          beatQ.push_back(b);
        end
      end
    end
  endtask

  task automatic checkOutput();
    logic busy;
    busy = (beatQ.size() > 0);
    checkEq("ready", 64'(ready), 64'(!rst && beatQ.size() <= 1));
    checkEq("intWe", 64'(intWe), 64'(expIntWe));
    if (expIntWe) begin
      checkEq("intAddr", 64'(intAddr), 64'(expIntAddr));
      checkEq("intData", 64'(intData), 64'(expIntData));
    end
    checkEq("vecWe", 64'(vecWe), 64'(busy));
    if (busy) begin
      checkEq("vecAddr", 64'(vecAddr), 64'(beatQ[0].addr));
      checkEq("vecBeat", 64'(vecBeat), 64'(beatQ[0].beat));
      checkEq("vecData", 64'(vecData), 64'(beatQ[0].data));
    end
    if (rst) begin
      checkEq("rstIntAddr", 64'(intAddr), 64'd0);
      checkEq("rstIntData", 64'(intData), 64'd0);
      checkEq("rstVecAddr", 64'(vecAddr), 64'd0);
      checkEq("rstVecBeat", 64'(vecBeat), 64'd0);
      checkEq("rstVecData", 64'(vecData), 64'd0);
    end
`ifdef WB_FWD_EN
    checkEq("fwdIntValid", 64'(fwdIntValid), 64'(expIntWe));
    if (expIntWe) begin
      checkEq("fwdIntReg", 64'(fwdIntReg), 64'(expIntAddr));
      checkEq("fwdIntData", 64'(fwdIntData), 64'(expIntData));
    end
    checkEq("fwdVecValid", 64'(fwdVecValid), 64'(busy));
    if (busy) begin
      checkEq("fwdVecReg", 64'(fwdVecReg), 64'(beatQ[0].addr));
      checkEq("fwdVecData", fwdVecData, beatQ[0].full);
    end
`else
    checkEq("fwdIntValid", 64'(fwdIntValid), 64'd0);
    checkEq("fwdIntReg", 64'(fwdIntReg), 64'd0);
    checkEq("fwdIntData", 64'(fwdIntData), 64'd0);
    checkEq("fwdVecValid", 64'(fwdVecValid), 64'd0);
    checkEq("fwdVecReg", 64'(fwdVecReg), 64'd0);
    checkEq("fwdVecData", fwdVecData, 64'd0);
`endif
  endtask

  task automatic cycle();
    @(posedge clk);
    modelEdge();
    @(negedge clk);
    checkOutput();
  endtask

  initial begin
    rst = 1'b1;
    idleInputs();

    // Reset state
    cycle();
    cycle();
    checkEq("resetReady", 64'(ready), 64'd0);
    rst = 1'b0;
    #1 checkEq("readyOutOfReset", 64'(ready), 64'd1);

    // Integer ALU write to r5
    applyStimulus(1'b1, 1'b0, 1'b1, 1'b0, 16'h1234, '0, '0, 4'd5, '0);
    cycle();
    checkEq("aluIntWe", 64'(intWe), 64'd1);
    checkEq("aluIntAddr", 64'(intAddr), 64'd5);
    checkEq("aluIntData", 64'(intData), 64'h1234);
    idleInputs();
    cycle();
    checkEq("aluIntWeOnce", 64'(intWe), 64'd0);

    // Memory vector load into v2, two beats
    applyStimulus(1'b1, 1'b1, 1'b0, 1'b1, '0, 64'hFFFF_FFFF_FFFF_FFFF,
                  64'h0807_0605_0403_0201, '0, 2'd2);
    cycle();
    checkEq("memBeat0Data", 64'(vecData), 64'h0403_0201);
    checkEq("memBeat0Addr", 64'(vecAddr), 64'd2);
    checkEq("memBeat0Ready", 64'(ready), 64'd0);
    idleInputs();
    cycle();
    checkEq("memBeat1Data", 64'(vecData), 64'h0807_0605);
    checkEq("memBeat1Beat", 64'(vecBeat), 64'd1);
    cycle();
    checkEq("memVecDone", 64'(vecWe), 64'd0);

    // Back-to-back vector entries with valid held high
    applyStimulus(1'b1, 1'b0, 1'b0, 1'b1, '0, 64'h1111_2222_3333_4444, '0, '0, 2'd1);
    cycle();
    applyStimulus(1'b1, 1'b0, 1'b0, 1'b1, '0, 64'hAAAA_BBBB_CCCC_DDDD, '0, '0, 2'd3);
    cycle();
    checkEq("b2bFirstLast", 64'(vecData), 64'h1111_2222);
    cycle();
    checkEq("b2bSecondBeat0", 64'(vecData), 64'hCCCC_DDDD);
    checkEq("b2bSecondAddr", 64'(vecAddr), 64'd3);
    idleInputs();
    cycle();
    checkEq("b2bSecondBeat1", 64'(vecData), 64'hAAAA_BBBB);
    cycle();

    // Write to r0 is dropped
    applyStimulus(1'b1, 1'b0, 1'b1, 1'b0, 16'hFFFF, '0, '0, 4'd0, '0);
    cycle();
    checkEq("r0NoWrite", 64'(intWe), 64'd0);
    idleInputs();
    cycle();

    // Reset during beat 0 aborts the vector write
    applyStimulus(1'b1, 1'b0, 1'b0, 1'b1, '0, 64'h0123_4567_89AB_CDEF, '0, '0, 2'd1);
    cycle();
    idleInputs();
    rst = 1'b1;
    #1 checkEq("readyInReset", 64'(ready), 64'd0);
    cycle();
    checkEq("abortNoBeat1", 64'(vecWe), 64'd0);
    rst = 1'b0;
    #1 checkEq("readyAfterRelease", 64'(ready), 64'd1);
    cycle();

    // Combined int + vector entry (forwarding view)
    applyStimulus(1'b1, 1'b0, 1'b1, 1'b1, 16'hBEEF, 64'hDEAD_BEEF_CAFE_F00D, '0, 4'd7, 2'd2);
    cycle();
    idleInputs();
`ifdef WB_FWD_EN
    checkEq("fwdIntPulse", 64'(fwdIntValid), 64'd1);
    checkEq("fwdVecFull0", fwdVecData, 64'hDEAD_BEEF_CAFE_F00D);
    cycle();
    checkEq("fwdIntOnce", 64'(fwdIntValid), 64'd0);
    checkEq("fwdVecBeat1", 64'(fwdVecValid), 64'd1);
    checkEq("fwdVecFull1", fwdVecData, 64'hDEAD_BEEF_CAFE_F00D);
`else
    checkEq("fwdOffInt", 64'(fwdIntValid), 64'd0);
    checkEq("fwdOffVec", 64'(fwdVecValid), 64'd0);
    cycle();
    checkEq("fwdOffData", fwdVecData, 64'd0);
`endif
    cycle();

    // Randomized traffic against the reference model
    for (int n = 0; n < 500; n++) begin
      rst = ($urandom_range(0, 39) == 0);
      applyStimulus($urandom_range(0, 9) < 7, 1'($urandom), 1'($urandom), 1'($urandom),
                    16'($urandom), {$urandom, $urandom}, {$urandom, $urandom},
                    4'($urandom_range(0, 15)), 2'($urandom));
      cycle();
    end
    rst = 1'b0;
    idleInputs();
    cycle();
    cycle();

    $display("[TB] directed and random sequences complete");
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
